// File: rtl/hwpe_ctrl_uloop_issue.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_uloop_issue
// Description : Pulls loop iterations from the uloop engine, forms per-stream
//               base+offset addresses and forks them to the streamers.
//               Optional macro HWPE_CTRL_ULOOP_ISSUE_PREFETCH_EN enables
//               multi-entry prefetch into the tuple FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_uloop_issue #(
    parameter int unsigned NB_STREAM  = 2,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 start_i,
    input  logic [NB_STREAM*ADDR_WIDTH-1:0]      base_addr_i,
    input  logic [NB_STREAM*$clog2(NB_REG)-1:0]  offs_sel_i,
    output logic                                 uloop_enable_o,
    input  logic                                 uloop_valid_i,
    input  logic                                 uloop_done_i,
    input  logic [NB_REG*REG_WIDTH-1:0]          uloop_offs_i,
    output logic [NB_STREAM-1:0]                 stream_valid_o,
    input  logic [NB_STREAM-1:0]                 stream_ready_i,
    output logic [NB_STREAM*ADDR_WIDTH-1:0]      stream_addr_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [CNT_WIDTH-1:0]                 nb_issued_o
);

    localparam int unsigned SEL_WIDTH   = $clog2(NB_REG);
    localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_WIDTH   = PTR_WIDTH + 1;
    localparam int unsigned EXT_WIDTH   = (REG_WIDTH > ADDR_WIDTH) ? REG_WIDTH : ADDR_WIDTH;
    localparam int unsigned TUPLE_WIDTH = NB_STREAM * ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [TUPLE_WIDTH-1:0]          base_q;
    logic [NB_STREAM*SEL_WIDTH-1:0]  sel_q;
    logic [TUPLE_WIDTH-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]            wr_ptr_q, rd_ptr_q;
    logic [OCC_WIDTH-1:0]            occ_q;
    logic [NB_STREAM-1:0]            accepted_q;
    logic [CNT_WIDTH-1:0]            nb_issued_q;
    logic [REG_WIDTH-1:0]            offs_arr [NB_REG];
    logic [TUPLE_WIDTH-1:0]          tuple;
    logic [NB_STREAM-1:0]            handshake;
    logic                            fifo_empty, slot_free, push, pop;

    generate
        for (genvar r = 0; r < NB_REG; r++) begin : g_reg
            assign offs_arr[r] = uloop_offs_i[r*REG_WIDTH +: REG_WIDTH];
        end

        for (genvar s = 0; s < NB_STREAM; s++) begin : g_addr
            logic [SEL_WIDTH-1:0] sel;
            logic [EXT_WIDTH-1:0] offs_ext;
            assign sel      = sel_q[s*SEL_WIDTH +: SEL_WIDTH];
            assign offs_ext = EXT_WIDTH'(offs_arr[sel]);
            assign tuple[s*ADDR_WIDTH +: ADDR_WIDTH] =
                base_q[s*ADDR_WIDTH +: ADDR_WIDTH] + offs_ext[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign fifo_empty     = (occ_q == '0);
    assign push           = (state_q == WAIT) && uloop_valid_i;
    assign stream_valid_o = {NB_STREAM{~fifo_empty}} & ~accepted_q;
    assign handshake      = stream_valid_o & stream_ready_i;
    // The head retires once every stream has taken it, now or earlier.
    assign pop            = ~fifo_empty && (&(accepted_q | handshake));

`ifdef HWPE_CTRL_ULOOP_ISSUE_PREFETCH_EN
    localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(FIFO_DEPTH);
    assign slot_free = (occ_q < FULL_OCC);
`else
    assign slot_free = fifo_empty;
`endif

    assign stream_addr_o = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign busy_o        = (state_q != IDLE);
    assign nb_issued_o   = nb_issued_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        uloop_enable_o = 1'b0;
        done_o         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = REQ;
            end
            REQ: begin
                if (slot_free) begin
                    uloop_enable_o = 1'b1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (uloop_done_i)       state_d = DRAIN;
                else if (uloop_valid_i) state_d = REQ;
            end
            DRAIN: begin
                if (fifo_empty || (occ_q == OCC_WIDTH'(1) && pop)) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            base_q      <= '0;
            sel_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            accepted_q  <= '0;
            nb_issued_q <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                base_q      <= base_addr_i;
                sel_q       <= offs_sel_i;
                nb_issued_q <= '0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                accepted_q <= '0;
                if (nb_issued_q != '1) nb_issued_q <= nb_issued_q + 1'b1;
            end else begin
                accepted_q <= accepted_q | handshake;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone qualifies the contents.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= tuple;
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_ctrl_uloop_issue
// Description : Scoreboard bench with a behavioural loop engine for
//               hwpe_ctrl_uloop_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_uloop_issue;

    localparam int NB_STREAM  = 2;
    localparam int NB_REG     = 4;
    localparam int REG_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_WIDTH  = 16;
`ifdef HWPE_CTRL_ULOOP_ISSUE_PREFETCH_EN
    localparam int EXP_STALL_REQS = FIFO_DEPTH;
`else
    localparam int EXP_STALL_REQS = 1;
`endif

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    logic                            clear_i;
    logic                            start_i;
    logic [NB_STREAM*ADDR_WIDTH-1:0] base_addr_i;
    logic [NB_STREAM*2-1:0]          offs_sel_i;
    logic                            uloop_enable_o;
    logic                            uloop_valid_i;
    logic                            uloop_done_i;
    logic [NB_REG*REG_WIDTH-1:0]     uloop_offs_i;
    logic [NB_STREAM-1:0]            stream_valid_o;
    logic [NB_STREAM-1:0]            stream_ready_i;
    logic [NB_STREAM*ADDR_WIDTH-1:0] stream_addr_o;
    logic                            busy_o;
    logic                            done_o;
    logic [CNT_WIDTH-1:0]            nb_issued_o;

    hwpe_ctrl_uloop_issue #(
        .NB_STREAM (NB_STREAM),
        .NB_REG    (NB_REG),
        .REG_WIDTH (REG_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .offs_sel_i    (offs_sel_i),
        .uloop_enable_o(uloop_enable_o),
        .uloop_valid_i (uloop_valid_i),
        .uloop_done_i  (uloop_done_i),
        .uloop_offs_i  (uloop_offs_i),
        .stream_valid_o(stream_valid_o),
        .stream_ready_i(stream_ready_i),
        .stream_addr_o (stream_addr_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .nb_issued_o   (nb_issued_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    int cyc = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int enables = 0;
    bit prev_en = 1'b0;

    int          eng_n = 1;
    int          eng_lat = 1;
    int          eng_iter = 0;
    bit          eng_novalid = 1'b0;
    logic [31:0] eng_exp0 = '0;
    logic [31:0] eng_exp1 = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: scoreboard pops on every streamer handshake.
    always @(negedge clk_i) begin
        cyc++;
        if (done_o) done_cyc = cyc;
        if (uloop_enable_o) enables++;
        if (uloop_enable_o && prev_en) begin
            checks++;
            errors++;
            $display("FAIL enable_pulse: got 2-cycle enable expected 1-cycle");
        end
        prev_en = uloop_enable_o;
        if (stream_valid_o[0] && stream_ready_i[0]) begin
            last_hs_cyc = cyc;
            if (exp0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_s0: got 0x%0h expected none", stream_addr_o[31:0]);
            end else begin
                check("sb_s0", stream_addr_o[31:0], exp0.pop_front());
            end
        end
        if (stream_valid_o[1] && stream_ready_i[1]) begin
            last_hs_cyc = cyc;
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_s1: got 0x%0h expected none", stream_addr_o[63:32]);
            end else begin
                check("sb_s1", stream_addr_o[63:32], exp1.pop_front());
            end
        end
    end

    // Loop engine model: answers each enable after eng_lat cycles.
    initial begin
        uloop_valid_i = 1'b0;
        uloop_done_i  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (uloop_enable_o) begin
                repeat (eng_lat) @(posedge clk_i);
                #1;
                eng_iter++;
                if (eng_iter >= eng_n) uloop_done_i = 1'b1;
                if (!(eng_novalid && eng_iter >= eng_n)) begin
                    uloop_valid_i = 1'b1;
                    exp0.push_back(eng_exp0);
                    exp1.push_back(eng_exp1);
                end
                @(posedge clk_i);
                #1;
                uloop_valid_i = 1'b0;
                uloop_done_i  = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    task automatic start_job(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [1:0] s0, input logic [1:0] s1,
                             input int n, input int lat, input bit novalid,
                             input logic [31:0] e0, input logic [31:0] e1);
        @(posedge clk_i);
        #1;
        base_addr_i = {b1, b0};
        offs_sel_i  = {s1, s0};
        eng_n       = n;
        eng_lat     = lat;
        eng_novalid = novalid;
        eng_exp0    = e0;
        eng_exp1    = e1;
        eng_iter    = 0;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max, input bit chk_lat);
        bit seen = 1'b0;
        int k = 0;
        while (k < max && !seen) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
            k++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done_o expected done_o within %0d cycles", name, max);
        end else begin
            @(negedge clk_i);
            if (chk_lat) check({name, "_done_lat"}, done_cyc, last_hs_cyc + 1);
            check({name, "_done_pulse"}, done_o, 1'b0);
            check({name, "_busy_low"}, busy_o, 1'b0);
        end
    endtask

    initial begin
        bit seen;
        rst_ni         = 1'b0;
        clear_i        = 1'b0;
        start_i        = 1'b0;
        base_addr_i    = '0;
        offs_sel_i     = '0;
        stream_ready_i = '0;
        uloop_offs_i   = {32'h0000_4444, 32'h0000_3333, 32'h0000_0020, 32'h0000_0010};

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_enable", uloop_enable_o, 1'b0);
        check("rst_valid", stream_valid_o, 2'b00);
        check("rst_addr", stream_addr_o, 64'h0);
        check("rst_issued", nb_issued_o, 16'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Basic job: three iterations, always ready
        stream_ready_i = 2'b11;
        start_job(32'h1000, 32'h2000, 2'd0, 2'd1, 3, 2, 1'b0, 32'h1010, 32'h2020);
        @(negedge clk_i);
        check("t1_busy", busy_o, 1'b1);
        wait_done("t1", 200, 1'b1);
        check("t1_issued", nb_issued_o, 16'd3);
        check("t1_sb_empty", {exp0.size() == 0, exp1.size() == 0}, 2'b11);

        // Skewed ready
        stream_ready_i = 2'b01;
        start_job(32'h1000, 32'h2000, 2'd0, 2'd1, 1, 1, 1'b0, 32'h1010, 32'h2020);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_i);
            if (stream_valid_o[0]) seen = 1'b1;
        end
        check("t2_first_valid", seen, 1'b1);
        @(negedge clk_i);
        check("t2_fork_valid", stream_valid_o, 2'b10);
        repeat (3) @(negedge clk_i);
        check("t2_hold_valid", stream_valid_o, 2'b10);
        check("t2_no_pop", nb_issued_o, 16'd0);
        @(posedge clk_i);
        #1;
        stream_ready_i = 2'b11;
        wait_done("t2", 50, 1'b1);
        check("t2_issued", nb_issued_o, 16'd1);

        // Backpressure, plus start_i while busy
        stream_ready_i = 2'b00;
        enables = 0;
        start_job(32'h100, 32'h200, 2'd2, 2'd3, 5, 1, 1'b0, 32'h3433, 32'h4644);
        repeat (30) @(negedge clk_i);
        check("t3_stall_reqs", enables, EXP_STALL_REQS);
        check("t3_enable_low", uloop_enable_o, 1'b0);
        check("t3_valid", stream_valid_o, 2'b11);
        @(posedge clk_i);
        #1;
        base_addr_i = {32'hDEAD_0000, 32'hBEEF_0000};
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        check("t3_start_ignored", enables, EXP_STALL_REQS);
        check("t3_still_busy", busy_o, 1'b1);
        @(posedge clk_i);
        #1;
        stream_ready_i = 2'b11;
        wait_done("t3", 300, 1'b1);
        check("t3_issued", nb_issued_o, 16'd5);
        check("t3_total_reqs", enables, 5);

        // Address wrap
        start_job(32'hFFFF_FFF0, 32'h0, 2'd1, 2'd3, 1, 1, 1'b0, 32'h10, 32'h4444);
        wait_done("t4", 50, 1'b1);
        check("t4_issued", nb_issued_o, 16'd1);

        // Done without valid
        start_job(32'h1000, 32'h2000, 2'd0, 2'd1, 2, 1, 1'b1, 32'h1010, 32'h2020);
        wait_done("t5", 100, 1'b0);
        check("t5_issued", nb_issued_o, 16'd1);
        check("t5_sb_empty", {exp0.size() == 0, exp1.size() == 0}, 2'b11);

        // Soft clear mid-job with tuples queued
        stream_ready_i = 2'b00;
        start_job(32'h1000, 32'h2000, 2'd0, 2'd1, 10, 1, 1'b0, 32'h1010, 32'h2020);
        repeat (20) @(negedge clk_i);
        check("t6_queued", stream_valid_o, 2'b11);
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        @(negedge clk_i);
        check("t6_clr_valid", stream_valid_o, 2'b00);
        check("t6_clr_busy", busy_o, 1'b0);
        check("t6_clr_addr", stream_addr_o, 64'h0);
        check("t6_clr_issued", nb_issued_o, 16'd0);
        exp0.delete();
        exp1.delete();

        // Recovery after clear
        stream_ready_i = 2'b11;
        start_job(32'h0, 32'h10, 2'd1, 2'd0, 2, 2, 1'b0, 32'h20, 32'h20);
        wait_done("t7", 100, 1'b1);
        check("t7_issued", nb_issued_o, 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
